video_compositor: RTL and testbench

- N-layer video compositor for the XGA video path. It generalises the fixed two-source "black is transparent" overlay into a parametrised, priority-ordered layer stack.
- Each layer has a programmable colour key and an enable. Configuration is double-buffered and committed on a frame boundary.
- Sync and data-enable are delay-matched through a 2-stage pipeline.
- It sits between the pixel sources (Xosera, framebuffer stream) and the VGA pins. It also generates the frame-start pulse for the framebuffer streamer.

---
 rtl/video_compositor_if.sv | 32 +++
 rtl/video_compositor.sv | 157 +++++++++++++++
 tb/tb_video_compositor.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_compositor_if.sv
// Pixel/sync/config bundle for the layer compositor.
// master drives timing, layer pixels and config writes; slave is the compositor.
interface video_compositor_if #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned COLOR_W    = 4
);
  localparam int unsigned PIX_W = 3 * COLOR_W;

  logic                        hsync_i;
  logic                        vsync_i;
  logic                        de_i;
  logic [NUM_LAYERS*PIX_W-1:0] layer_rgb_i;
  logic                        cfg_wr_i;
  logic [7:0]                  cfg_addr_i;
  logic [31:0]                 cfg_data_i;
  logic                        hsync_o;
  logic                        vsync_o;
  logic                        de_o;
  logic [PIX_W-1:0]            rgb_o;
  logic                        frame_o;
  logic                        cfg_pending_o;

  modport master (
    output hsync_i, vsync_i, de_i, layer_rgb_i, cfg_wr_i, cfg_addr_i, cfg_data_i,
    input  hsync_o, vsync_o, de_o, rgb_o, frame_o, cfg_pending_o
  );

  modport slave (
    input  hsync_i, vsync_i, de_i, layer_rgb_i, cfg_wr_i, cfg_addr_i, cfg_data_i,
    output hsync_o, vsync_o, de_o, rgb_o, frame_o, cfg_pending_o
  );
endinterface

// File: rtl/video_compositor.sv
// Priority-ordered N-layer colour-key compositor with frame-committed shadow config.
// Define VIDEO_COMPOSITOR_BLEND_EN to enable per-layer 50% blending.
module video_compositor #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned COLOR_W    = 4
) (
  input logic               clk,
  input logic               reset_n_i,
  video_compositor_if.slave bus
);
  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam int unsigned IDX_W = 6;

  typedef struct packed {
    logic             enable;
    logic             key_en;
    logic             blend;
    logic [PIX_W-1:0] key;
  } layer_cfg_t;

  localparam layer_cfg_t CFG_RST = '{enable: 1'b1, key_en: 1'b1, blend: 1'b0, key: '0};

  layer_cfg_t                  shd_cfg   [NUM_LAYERS];
  layer_cfg_t                  act_cfg   [NUM_LAYERS];
  layer_cfg_t                  shd_cfg_c [NUM_LAYERS];
  logic [PIX_W-1:0]            shd_bg, act_bg, shd_bg_c;
  logic [IDX_W-1:0]            wr_layer_c;
  logic [1:0]                  wr_reg_c;
  logic                        wr_hit_c;
  logic                        prev_vsync;
  logic                        s1_hsync, s1_vsync, s1_de;
  logic [NUM_LAYERS*PIX_W-1:0] s1_pix;
  logic [NUM_LAYERS-1:0]       s1_transp, transp_c;
  logic [NUM_LAYERS-1:0]       blend_bits_c;
  logic [PIX_W-1:0]            acc_c;
  logic                        cfg_unused_c;

`ifdef VIDEO_COMPOSITOR_BLEND_EN
  function automatic logic [PIX_W-1:0] blend_avg(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
    logic [COLOR_W:0] sum;
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      sum = (COLOR_W+1)'(a[c*COLOR_W +: COLOR_W]) + (COLOR_W+1)'(b[c*COLOR_W +: COLOR_W]);
      r[c*COLOR_W +: COLOR_W] = sum[COLOR_W:1];
    end
    return r;
  endfunction
`endif

  assign wr_layer_c = bus.cfg_addr_i[7:2];
  assign wr_reg_c   = bus.cfg_addr_i[1:0];

  // Shadow register write decode; unmapped or reserved writes leave no trace.
  always_comb begin
    shd_cfg_c = shd_cfg;
    shd_bg_c  = shd_bg;
    wr_hit_c  = 1'b0;
    if (bus.cfg_wr_i) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        if (wr_layer_c == IDX_W'(k)) begin
          case (wr_reg_c)
            2'd0: begin
              shd_cfg_c[k].enable = bus.cfg_data_i[0];
              shd_cfg_c[k].key_en = bus.cfg_data_i[1];
              shd_cfg_c[k].blend  = bus.cfg_data_i[2];
              wr_hit_c            = 1'b1;
            end
            2'd1: begin
              shd_cfg_c[k].key = bus.cfg_data_i[PIX_W-1:0];
              wr_hit_c         = 1'b1;
            end
            default: ;
          endcase
        end
      end
      if (wr_layer_c == IDX_W'(NUM_LAYERS) && wr_reg_c == 2'd0) begin
        shd_bg_c = bus.cfg_data_i[PIX_W-1:0];
        wr_hit_c = 1'b1;
      end
    end
  end

  // Stage-1 transparency against the active key set.
  always_comb begin
    transp_c     = '0;
    blend_bits_c = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      transp_c[k] = ~act_cfg[k].enable |
                    (act_cfg[k].key_en & (bus.layer_rgb_i[k*PIX_W +: PIX_W] == act_cfg[k].key));
      blend_bits_c[k] = act_cfg[k].blend;
    end
  end

  // Bottom-up composition: each opaque layer overrides (or blends into) what is below.
  always_comb begin
    acc_c = act_bg;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (!s1_transp[k]) begin
`ifdef VIDEO_COMPOSITOR_BLEND_EN
        if (act_cfg[k].blend) acc_c = blend_avg(acc_c, s1_pix[k*PIX_W +: PIX_W]);
        else                  acc_c = s1_pix[k*PIX_W +: PIX_W];
`else
        acc_c = s1_pix[k*PIX_W +: PIX_W];
`endif
      end
    end
  end

  assign cfg_unused_c = ^{bus.cfg_data_i[31:PIX_W], blend_bits_c};

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        shd_cfg[k] <= CFG_RST;
        act_cfg[k] <= CFG_RST;
      end
      shd_bg            <= '0;
      act_bg            <= '0;
      prev_vsync        <= 1'b0;
      s1_hsync          <= 1'b0;
      s1_vsync          <= 1'b0;
      s1_de             <= 1'b0;
      s1_pix            <= '0;
      s1_transp         <= '0;
      bus.hsync_o       <= 1'b0;
      bus.vsync_o       <= 1'b0;
      bus.de_o          <= 1'b0;
      bus.rgb_o         <= '0;
      bus.frame_o       <= 1'b0;
      bus.cfg_pending_o <= 1'b0;
    end else begin
      prev_vsync  <= bus.vsync_i;
      bus.frame_o <= prev_vsync & ~bus.vsync_i;
      shd_cfg     <= shd_cfg_c;
      shd_bg      <= shd_bg_c;
      // Commit includes a write landing in the same cycle as the frame pulse.
      if (bus.frame_o) begin
        act_cfg           <= shd_cfg_c;
        act_bg            <= shd_bg_c;
        bus.cfg_pending_o <= 1'b0;
      end else if (wr_hit_c) begin
        bus.cfg_pending_o <= 1'b1;
      end
      s1_hsync    <= bus.hsync_i;
      s1_vsync    <= bus.vsync_i;
      s1_de       <= bus.de_i;
      s1_pix      <= bus.layer_rgb_i;
      s1_transp   <= transp_c;
      bus.hsync_o <= s1_hsync;
      bus.vsync_o <= s1_vsync;
      bus.de_o    <= s1_de;
      bus.rgb_o   <= s1_de ? acc_c : '0;
    end
  end
endmodule

// File: tb/tb_video_compositor.sv
// Directed + randomized bench for video_compositor with a frame-level reference model.
module tb_video_compositor;
  localparam int unsigned NL = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = 3 * CW;

  logic clk;
  logic rst_n;

  video_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) bus ();

  video_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW)) dut (
    .clk      (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          hs;
    logic          vs;
    logic          de;
    logic [PW-1:0] rgb;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests;
  int            n_fail;
  logic [PW-1:0] l0, l1;

  // Reference config: shadow copy written by the bus, active copy used for pixels.
  bit            sh_en [NL], sh_ken [NL], sh_bl [NL];
  logic [PW-1:0] sh_key[NL];
  logic [PW-1:0] sh_bg;
  bit            ac_en [NL], ac_ken [NL], ac_bl [NL];
  logic [PW-1:0] ac_key[NL];
  logic [PW-1:0] ac_bg;
  bit            m_prev_vs, m_frame, m_pend;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_pix(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] avg_pix(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] r;
    int ca, cb;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ca = int'((a >> (CW * c)) & 12'hF);
      cb = int'((b >> (CW * c)) & 12'hF);
      r  = r | PW'(((ca + cb) / 2) << (CW * c));
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] composite(input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                                              input logic de);
    logic [PW-1:0] p[NL];
    logic [PW-1:0] acc;
    bit            opaque;
    p[0] = p0;
    p[1] = p1;
    acc  = ac_bg;
    for (int k = 0; k < NL; k++) begin
      opaque = ac_en[k] && !(ac_ken[k] && (p[k] == ac_key[k]));
      if (opaque) begin
`ifdef VIDEO_COMPOSITOR_BLEND_EN
        acc = ac_bl[k] ? avg_pix(acc, p[k]) : p[k];
`else
        acc = p[k];
`endif
      end
    end
    return de ? acc : '0;
  endfunction

  function automatic bit model_write(input logic [7:0] a, input logic [31:0] d);
    int layer, r;
    bit hit;
    layer = int'(a) / 4;
    r     = int'(a) % 4;
    hit   = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (layer == k) begin
        if (r == 0) begin
          sh_en[k]  = d[0];
          sh_ken[k] = d[1];
          sh_bl[k]  = d[2];
          hit       = 1'b1;
        end else if (r == 1) begin
          sh_key[k] = d[PW-1:0];
          hit       = 1'b1;
        end
      end
    end
    if (layer == int'(NL) && r == 0) begin
      sh_bg = d[PW-1:0];
      hit   = 1'b1;
    end
    return hit;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      sh_en[k] = 1'b1; sh_ken[k] = 1'b1; sh_bl[k] = 1'b0; sh_key[k] = '0;
      ac_en[k] = 1'b1; ac_ken[k] = 1'b1; ac_bl[k] = 1'b0; ac_key[k] = '0;
    end
    sh_bg     = '0;
    ac_bg     = '0;
    m_prev_vs = 1'b0;
    m_frame   = 1'b0;
    m_pend    = 1'b0;
  endtask

  task automatic commit_model();
    for (int k = 0; k < NL; k++) begin
      ac_en[k] = sh_en[k]; ac_ken[k] = sh_ken[k]; ac_bl[k] = sh_bl[k]; ac_key[k] = sh_key[k];
    end
    ac_bg = sh_bg;
  endtask

  // One pixel clock: predict, advance the model across the edge, compare outputs.
  task automatic step();
    exp_t e;
    bit   hit, nf;
    bus.layer_rgb_i = {l1, l0};
    e.hs  = bus.hsync_i;
    e.vs  = bus.vsync_i;
    e.de  = bus.de_i;
    e.rgb = composite(l0, l1, bus.de_i);
    exp_q.push_back(e);
    hit = bus.cfg_wr_i ? model_write(bus.cfg_addr_i, bus.cfg_data_i) : 1'b0;
    nf  = m_prev_vs && !bus.vsync_i;
    if (m_frame) begin
      commit_model();
      m_pend = 1'b0;
    end else if (hit) begin
      m_pend = 1'b1;
    end
    m_prev_vs = bus.vsync_i;
    m_frame   = nf;
    @(posedge clk);
    #1;
    bus.cfg_wr_i = 1'b0;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_bit("hsync_o", bus.hsync_o, e.hs);
      check_bit("vsync_o", bus.vsync_o, e.vs);
      check_bit("de_o", bus.de_o, e.de);
      check_pix("rgb_o", bus.rgb_o, e.rgb);
    end
    check_bit("frame_o", bus.frame_o, m_frame);
    check_bit("cfg_pending_o", bus.cfg_pending_o, m_pend);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    bus.cfg_wr_i   = 1'b1;
    bus.cfg_addr_i = a;
    bus.cfg_data_i = d;
    step();
  endtask

  task automatic commit_frame();
    bus.de_i = 1'b0;
    repeat (3) step();
    bus.vsync_i = 1'b0;
    step();
    check_bit("frame_pulse", bus.frame_o, 1'b1);
    repeat (2) step();
    bus.vsync_i = 1'b1;
    repeat (2) step();
  endtask

  task automatic do_reset();
    exp_t z;
    bus.cfg_wr_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_bit("rst_hsync_o", bus.hsync_o, 1'b0);
    check_bit("rst_vsync_o", bus.vsync_o, 1'b0);
    check_bit("rst_de_o", bus.de_o, 1'b0);
    check_pix("rst_rgb_o", bus.rgb_o, '0);
    check_bit("rst_frame_o", bus.frame_o, 1'b0);
    check_bit("rst_pending", bus.cfg_pending_o, 1'b0);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    z.hs = 1'b0; z.vs = 1'b0; z.de = 1'b0; z.rgb = '0;
    exp_q.push_back(z);
  endtask

  function automatic logic [PW-1:0] pick_pix();
    case ($urandom_range(0, 3))
      0:       return 12'h000;
      1:       return 12'hF00;
      2:       return 12'h123;
      default: return PW'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] a;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.hsync_i = 1'b0; bus.vsync_i = 1'b1; bus.de_i = 1'b0;
    bus.layer_rgb_i = '0; bus.cfg_wr_i = 1'b0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
    l0 = '0; l1 = '0;
    do_reset();

    // Defaults: black on top layer is transparent.
    l1 = 12'h000; l0 = 12'hABC; bus.de_i = 1'b1;
    repeat (3) step();
    check_pix("dflt_l0_shows", bus.rgb_o, 12'hABC);
    l1 = 12'h123;
    repeat (3) step();
    check_pix("dflt_l1_on_top", bus.rgb_o, 12'h123);

    // Arbitrary sync/de pattern, 2-cycle delay and blanking.
    repeat (40) begin
      bus.hsync_i = 1'($urandom); bus.vsync_i = 1'($urandom); bus.de_i = 1'($urandom);
      l0 = PW'($urandom); l1 = pick_pix();
      step();
    end
    bus.vsync_i = 1'b1; bus.de_i = 1'b0;
    repeat (3) step();

    // Shadow write mid-frame has no visible effect until commit.
    l1 = 12'h123; l0 = 12'hABC; bus.de_i = 1'b1;
    repeat (2) step();
    cfg_write(8'h04, 32'h0);
    check_bit("pending_set", bus.cfg_pending_o, 1'b1);
    repeat (3) step();
    check_pix("shadow_no_effect", bus.rgb_o, 12'h123);
    commit_frame();
    check_bit("pending_cleared", bus.cfg_pending_o, 1'b0);
    bus.de_i = 1'b1;
    repeat (3) step();
    check_pix("l1_disabled", bus.rgb_o, 12'hABC);

    // Write coincident with frame_o is part of that commit.
    bus.de_i = 1'b0;
    repeat (2) step();
    bus.vsync_i = 1'b0;
    step();
    check_bit("frame_for_coinc", bus.frame_o, 1'b1);
    cfg_write(8'h04, 32'h3);
    check_bit("coinc_no_pending", bus.cfg_pending_o, 1'b0);
    bus.vsync_i = 1'b1;
    step();
    bus.de_i = 1'b1;
    repeat (3) step();
    check_pix("coinc_applied", bus.rgb_o, 12'h123);

    // Key colour and background.
    cfg_write(8'h05, 32'hF00);
    cfg_write(8'h08, 32'h0F0);
    commit_frame();
    l1 = 12'hF00; l0 = 12'h000; bus.de_i = 1'b1;
    repeat (3) step();
    check_pix("background", bus.rgb_o, 12'h0F0);

    // Out-of-range layer index.
    cfg_write(8'h0C, 32'h555);
    check_bit("invalid_no_pend", bus.cfg_pending_o, 1'b0);
    cfg_write(8'h0F, 32'hFFF);
    check_bit("invalid2_no_pend", bus.cfg_pending_o, 1'b0);
    commit_frame();
    bus.de_i = 1'b1;
    repeat (3) step();
    check_pix("invalid_no_effect", bus.rgb_o, 12'h0F0);

    // Blend bit on layer 1.
    cfg_write(8'h04, 32'h7);
    commit_frame();
    l1 = 12'hEEE; l0 = 12'h222; bus.de_i = 1'b1;
    repeat (3) step();
`ifdef VIDEO_COMPOSITOR_BLEND_EN
    check_pix("blend", bus.rgb_o, 12'h888);
`else
    check_pix("blend_off", bus.rgb_o, 12'hEEE);
`endif

    // Randomized frames: random writes and pixels, commits during blanking.
    repeat (6) begin
      repeat (24) begin
        bus.hsync_i = 1'($urandom); bus.de_i = 1'($urandom);
        l0 = pick_pix(); l1 = pick_pix();
        if ($urandom_range(0, 3) == 0) begin
          a = 8'($urandom_range(0, 15));
          cfg_write(a, ($urandom_range(0, 1) != 0) ? 32'(pick_pix()) : $urandom);
        end else begin
          step();
        end
      end
      commit_frame();
    end

    // Reset during active video with a write pending.
    l1 = 12'h123; l0 = 12'hABC; bus.de_i = 1'b1;
    cfg_write(8'h04, 32'h0);
    check_bit("pre_reset_pending", bus.cfg_pending_o, 1'b1);
    do_reset();
    l1 = 12'h000; l0 = 12'hABC;
    repeat (3) step();
    check_pix("post_reset_defaults", bus.rgb_o, 12'hABC);
    commit_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
